// File: rtl/divider_ctrl_pkg.sv
// Shared types and constants for the divider controller.
package divider_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int MIN_RATIO = 2;
  localparam int M_DEF     = 10;
  localparam int N_DEF     = 1000;

endpackage

// File: rtl/divider_ctrl_tick_counter.sv
// Wrap-around divide-by-ratio counter with a registered terminal-count flag.
// tc is high exactly while count holds ratio-1 and the counter is enabled.
module tick_counter
  import divider_ctrl_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [M-1:0] ratio,
  output logic [M-1:0] count,
  output logic         tc
);

  localparam logic [M-1:0] ONE = M'(1);

  logic [M-1:0] count_r;
  logic [M-1:0] count_nxt_s;
  logic         tc_r;

  // Next count: wrap to zero on the terminal value of the active ratio.
  always_comb begin
    count_nxt_s = count_r;
    if (count_r == (ratio - ONE)) begin
      count_nxt_s = {M{1'b0}};
    end else begin
      count_nxt_s = count_r + ONE;
    end
  end

  // Count register and terminal flag, cleared whenever counting is not active.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {M{1'b0}};
      tc_r    <= 1'b0;
    end else if (clr) begin
      count_r <= {M{1'b0}};
      tc_r    <= 1'b0;
    end else if (en) begin
      count_r <= count_nxt_s;
      tc_r    <= (count_nxt_s == (ratio - ONE));
    end else begin
      count_r <= count_r;
      tc_r    <= tc_r;
    end
  end

  assign count = count_r;
  assign tc    = tc_r;

endmodule

// File: rtl/divider_ctrl.sv
// Programmable tick controller: run/stop FSM, burst counting and glitch-free
// ratio updates that only take effect at period boundaries.
module divider_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int M         = M_DEF,
  parameter int N_DEFAULT = N_DEF
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         CFG_WE,
  input  logic [M-1:0] CFG_N,
  input  logic         START,
  input  logic         STOP,
  input  logic [M-1:0] BURST,
  output logic [M-1:0] COUNT,
  output logic         TICK,
  output logic         BUSY,
  output logic         DONE,
  output logic         CFG_ACK,
  output logic         ERR
);

  localparam logic [M-1:0] ONE   = M'(1);
  localparam logic [M-1:0] N_RST = M'(N_DEFAULT);
  localparam logic [M-1:0] MIN_N = M'(MIN_RATIO);

  state_t       state_r, state_nxt_s;
  logic [M-1:0] n_act_r, n_act_nxt_s;
  logic [M-1:0] pend_r, pend_nxt_s;
  logic         pend_vld_r, pend_vld_nxt_s;
  logic [M-1:0] ticks_left_r, ticks_left_nxt_s;
  logic         ack_r, ack_nxt_s;
  logic         err_r, busy_r, done_r;
  logic         cnt_en_s, cnt_clr_s, tc_s, wrap_s, cfg_ok_s, cfg_bad_s;
  logic [M-1:0] count_s;

  assign cfg_ok_s  = CFG_WE && (CFG_N >= MIN_N);
  assign cfg_bad_s = CFG_WE && (CFG_N < MIN_N);
  assign wrap_s    = (state_r == RUN) && tc_s;
  assign cnt_en_s  = (state_r == RUN) && (state_nxt_s == RUN);
  assign cnt_clr_s = !cnt_en_s;

  // Next-state logic; STOP has priority over START and over a final wrap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (START && !STOP) state_nxt_s = RUN;
        else                state_nxt_s = IDLE;
      end
      RUN: begin
        if (STOP)                                state_nxt_s = IDLE;
        else if (wrap_s && ticks_left_r == ONE)  state_nxt_s = FIN;
        else                                     state_nxt_s = RUN;
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ratio update: immediate outside RUN, deferred to the next wrap inside RUN;
  // leaving RUN flushes the newest requested ratio.
  always_comb begin
    n_act_nxt_s    = n_act_r;
    pend_nxt_s     = pend_r;
    pend_vld_nxt_s = pend_vld_r;
    ack_nxt_s      = 1'b0;
    if (state_r != RUN) begin
      if (cfg_ok_s) begin
        n_act_nxt_s = CFG_N;
        ack_nxt_s   = 1'b1;
      end else begin
        n_act_nxt_s = n_act_r;
      end
    end else if (state_nxt_s != RUN) begin
      pend_vld_nxt_s = 1'b0;
      if (cfg_ok_s) begin
        n_act_nxt_s = CFG_N;
        ack_nxt_s   = 1'b1;
      end else if (pend_vld_r) begin
        n_act_nxt_s = pend_r;
        ack_nxt_s   = 1'b1;
      end else begin
        n_act_nxt_s = n_act_r;
      end
    end else begin
      // A write landing on the wrap cycle waits for the following wrap.
      if (wrap_s && pend_vld_r) begin
        n_act_nxt_s    = pend_r;
        ack_nxt_s      = 1'b1;
        pend_vld_nxt_s = 1'b0;
      end else begin
        n_act_nxt_s = n_act_r;
      end
      if (cfg_ok_s) begin
        pend_nxt_s     = CFG_N;
        pend_vld_nxt_s = 1'b1;
      end else begin
        pend_nxt_s = pend_r;
      end
    end
  end

  // Burst bookkeeping; zero means free-running and is never decremented.
  always_comb begin
    ticks_left_nxt_s = ticks_left_r;
    if (state_r == IDLE && state_nxt_s == RUN) begin
      ticks_left_nxt_s = BURST;
    end else if (state_nxt_s != RUN) begin
      ticks_left_nxt_s = {M{1'b0}};
    end else if (wrap_s && ticks_left_r != {M{1'b0}}) begin
      ticks_left_nxt_s = ticks_left_r - ONE;
    end else begin
      ticks_left_nxt_s = ticks_left_r;
    end
  end

  // Control and status registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      n_act_r      <= N_RST;
      pend_r       <= {M{1'b0}};
      pend_vld_r   <= 1'b0;
      ticks_left_r <= {M{1'b0}};
      ack_r        <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      n_act_r      <= n_act_nxt_s;
      pend_r       <= pend_nxt_s;
      pend_vld_r   <= pend_vld_nxt_s;
      ticks_left_r <= ticks_left_nxt_s;
      ack_r        <= ack_nxt_s;
      err_r        <= cfg_bad_s;
      busy_r       <= (state_nxt_s == RUN);
      done_r       <= (state_nxt_s == FIN);
    end
  end

  tick_counter #(.M(M)) u_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .en    (cnt_en_s),
    .clr   (cnt_clr_s),
    .ratio (n_act_r),
    .count (count_s),
    .tc    (tc_s)
  );

  assign COUNT   = count_s;
  assign TICK    = tc_s;
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign CFG_ACK = ack_r;
  assign ERR     = err_r;

endmodule
